// File: rtl/data_mem_stage.sv
// MIPS32 data memory stage: combinational loads, edge-committed byte/half/word stores,
// misalignment detection with a sticky fault register. Optional counters via DMEM_STATS_EN.
module data_mem_stage #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        err_valid,
    output logic [31:0] err_addr,
    input  logic        err_clr,
`ifdef DMEM_STATS_EN
    output logic [31:0] ld_count,
    output logic [31:0] st_count,
`endif
    output logic        err_is_store
);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          misaligned;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   word_rd;
    logic [31:0]   ld_val;

    assign idx     = addr[AW+1:2];
    assign word_rd = mem[idx];

    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    assign misalign = (mem_read | mem_write) & misaligned;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b1111;
        wlane = wdata;
        unique case (size)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_write && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        h = 16'h0000;
        unique case (addr[1:0])
            2'b00:   b = word_rd[7:0];
            2'b01:   b = word_rd[15:8];
            2'b10:   b = word_rd[23:16];
            default: b = word_rd[31:24];
        endcase
        h = addr[1] ? word_rd[31:16] : word_rd[15:0];
        unique case (size)
            2'b00:   ld_val = ld_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   ld_val = ld_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            default: ld_val = word_rd;
        endcase
    end

    assign rdata = (mem_read && !misalign && rst_n) ? ld_val : 32'h0;

    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_is_store_q, err_is_store_d;

    // A new fault wins over a clear; otherwise the first fault is held until cleared.
    always_comb begin
        err_valid_d    = err_valid_q;
        err_addr_d     = err_addr_q;
        err_is_store_d = err_is_store_q;
        if (misalign && (!err_valid_q || err_clr)) begin
            err_valid_d    = 1'b1;
            err_addr_d     = addr;
            err_is_store_d = mem_write;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q    <= 1'b0;
            err_addr_q     <= 32'h0;
            err_is_store_q <= 1'b0;
        end else begin
            err_valid_q    <= err_valid_d;
            err_addr_q     <= err_addr_d;
            err_is_store_q <= err_is_store_d;
        end
    end

    assign err_valid    = err_valid_q;
    assign err_addr     = err_addr_q;
    assign err_is_store = err_is_store_q;

`ifdef DMEM_STATS_EN
    logic [31:0] ld_count_q, st_count_q;
    logic        ld_hit, st_hit;

    assign st_hit = mem_write && !misalign;
    assign ld_hit = mem_read && !mem_write && !misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_count_q <= 32'h0;
            st_count_q <= 32'h0;
        end else begin
            if (ld_hit && ld_count_q != 32'hFFFF_FFFF) ld_count_q <= ld_count_q + 32'd1;
            if (st_hit && st_count_q != 32'hFFFF_FFFF) st_count_q <= st_count_q + 32'd1;
        end
    end

    assign ld_count = ld_count_q;
    assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: stimulus queues expected values, a negedge monitor
// pops and compares them. Counter checks are compiled in when DMEM_STATS_EN is defined.
module tb_data_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] rdata;
    logic        misalign;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_is_store;
    logic        err_clr;
`ifdef DMEM_STATS_EN
    logic [31:0] ld_count;
    logic [31:0] st_count;
`endif

    data_mem_stage #(
        .DEPTH_WORDS(256),
        .AW         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .wdata       (wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .rdata       (rdata),
        .misalign    (misalign),
        .err_valid   (err_valid),
        .err_addr    (err_addr),
        .err_clr     (err_clr),
`ifdef DMEM_STATS_EN
        .ld_count    (ld_count),
        .st_count    (st_count),
`endif
        .err_is_store(err_is_store)
    );

    localparam int unsigned SigRdata = 0;
    localparam int unsigned SigMis   = 1;
    localparam int unsigned SigEv    = 2;
    localparam int unsigned SigEa    = 3;
    localparam int unsigned SigEs    = 4;
    localparam int unsigned SigLd    = 5;
    localparam int unsigned SigSt    = 6;

    typedef struct {
        string       name;
        int unsigned sig;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(int unsigned sig);
        case (sig)
            SigRdata: return rdata;
            SigMis:   return {31'h0, misalign};
            SigEv:    return {31'h0, err_valid};
            SigEa:    return err_addr;
            SigEs:    return {31'h0, err_is_store};
`ifdef DMEM_STATS_EN
            SigLd:    return ld_count;
            SigSt:    return st_count;
`endif
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: everything queued during a cycle is checked at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t   e;
                logic [31:0] a;
                e = q.pop_front();
                a = actual(e.sig);
                n_vec++;
                if (a !== e.exp) begin
                    n_miss++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int unsigned sig, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit clr);
        mem_read    = rd;
        mem_write   = wr;
        size        = sz;
        ld_unsigned = uns;
        addr        = a;
        wdata       = wd;
        err_clr     = clr;
    endtask

    task automatic idle();
        req(0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        next_cycle();
        next_cycle();
        // Load requested while in reset must read zero.
        req(1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        chk("rst_rdata", SigRdata, 32'h0);
        chk("rst_err_valid", SigEv, 32'h0);
        chk("rst_err_addr", SigEa, 32'h0);
        chk("rst_err_is_store", SigEs, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        chk("sw_misalign", SigMis, 32'h0);
        next_cycle();
        req(1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        chk("lw_10", SigRdata, 32'hDEADBEEF);
        next_cycle();
        req(1, 0, 2'b00, 0, 32'h13, 32'h0, 0);
        chk("lb_13", SigRdata, 32'hFFFFFFDE);
        next_cycle();
        req(1, 0, 2'b00, 1, 32'h13, 32'h0, 0);
        chk("lbu_13", SigRdata, 32'h000000DE);
        next_cycle();
        req(1, 0, 2'b01, 0, 32'h12, 32'h0, 0);
        chk("lh_12", SigRdata, 32'hFFFFDEAD);
        next_cycle();
        req(1, 0, 2'b01, 1, 32'h10, 32'h0, 0);
        chk("lhu_10", SigRdata, 32'h0000BEEF);
        next_cycle();
        req(0, 1, 2'b00, 0, 32'h11, 32'h000000AA, 0);
        next_cycle();
        req(1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        chk("lw_after_sb", SigRdata, 32'hDEADAAEF);
        next_cycle();
        req(0, 1, 2'b01, 0, 32'h12, 32'h00001234, 0);
        next_cycle();
        req(1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        chk("lw_after_sh", SigRdata, 32'h1234AAEF);
        next_cycle();
        req(0, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 0);
        next_cycle();

        // Fault capture, hold and drop.
        req(1, 0, 2'b10, 0, 32'h22, 32'h0, 0);
        chk("lw_22_misalign", SigMis, 32'h1);
        chk("lw_22_rdata", SigRdata, 32'h0);
        chk("lw_22_ev_before", SigEv, 32'h0);
        next_cycle();
        req(0, 1, 2'b01, 0, 32'h31, 32'h0000FFFF, 0);
        chk("sh_31_misalign", SigMis, 32'h1);
        chk("fault1_ev", SigEv, 32'h1);
        chk("fault1_ea", SigEa, 32'h22);
        chk("fault1_es", SigEs, 32'h0);
        next_cycle();
        req(0, 0, 2'b10, 0, 32'h23, 32'h0, 0);
        chk("idle_misalign", SigMis, 32'h0);
        chk("drop_ea", SigEa, 32'h22);
        chk("drop_es", SigEs, 32'h0);
        next_cycle();
        req(1, 0, 2'b10, 0, 32'h30, 32'h0, 0);
        chk("word30_kept", SigRdata, 32'hCAFEF00D);
        next_cycle();
        req(0, 0, 2'b10, 0, 32'h0, 32'h0, 1);
        next_cycle();
        idle();
        chk("clr_ev", SigEv, 32'h0);
        chk("clr_ea_kept", SigEa, 32'h22);
        req(0, 1, 2'b10, 0, 32'h41, 32'h12345678, 1);
        next_cycle();
        idle();
        chk("clr_new_ev", SigEv, 32'h1);
        chk("clr_new_ea", SigEa, 32'h41);
        chk("clr_new_es", SigEs, 32'h1);

        // Read-during-write and aliasing.
        req(0, 1, 2'b10, 0, 32'h50, 32'h22222222, 0);
        next_cycle();
        req(1, 1, 2'b10, 0, 32'h50, 32'h11111111, 0);
        chk("rdw_old", SigRdata, 32'h22222222);
        next_cycle();
        req(1, 0, 2'b10, 0, 32'h50, 32'h0, 0);
        chk("rdw_new", SigRdata, 32'h11111111);
        next_cycle();
        req(1, 0, 2'b10, 0, 32'h450, 32'h0, 0);
        chk("alias_450", SigRdata, 32'h11111111);
        next_cycle();

        // Reset asserted before the edge of an in-flight store.
        req(0, 1, 2'b10, 0, 32'h50, 32'h33333333, 0);
        #2;
        rst_n = 1'b0;
        chk("rst_mid_ev", SigEv, 32'h0);
        chk("rst_mid_ea", SigEa, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        req(1, 0, 2'b10, 0, 32'h50, 32'h0, 0);
        chk("rst_no_write", SigRdata, 32'h11111111);
        chk("rst_ev_after", SigEv, 32'h0);
`ifdef DMEM_STATS_EN
        chk("cnt_ld_zero", SigLd, 32'h0);
        chk("cnt_st_zero", SigSt, 32'h0);
`endif
        next_cycle();

`ifdef DMEM_STATS_EN
        // The load above was good; two more loads, two stores, one faulting load.
        req(1, 0, 2'b00, 0, 32'h13, 32'h0, 0);
        next_cycle();
        req(1, 0, 2'b01, 1, 32'h10, 32'h0, 0);
        next_cycle();
        req(0, 1, 2'b10, 0, 32'h60, 32'h0, 0);
        next_cycle();
        req(0, 1, 2'b00, 0, 32'h61, 32'h0, 0);
        next_cycle();
        req(1, 0, 2'b10, 0, 32'h62, 32'h0, 0);
        next_cycle();
        idle();
        chk("cnt_ld_3", SigLd, 32'd3);
        chk("cnt_st_2", SigSt, 32'd2);
        next_cycle();
        rst_n = 1'b0;
        chk("cnt_ld_rst", SigLd, 32'h0);
        chk("cnt_st_rst", SigSt, 32'h0);
        next_cycle();
        rst_n = 1'b1;
`endif

        idle();
        next_cycle();
        next_cycle();
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- Data memory stage directly downstream of the ALU in the single-cycle MIPS32 datapath.
- The ALU result is the effective address. The stage serves LW/LH/LHU/LB/LBU loads and SW/SH/SB stores against on-chip word-organised RAM.
- Loads read combinationally so the result reaches write-back in the same cycle. Stores commit on the clock edge.
- Misaligned accesses are detected, suppressed and captured in a sticky fault register for the exception logic.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..65536.
- AW, 8, word-index width; must equal log2(DEPTH_WORDS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  32  byte address, driven from the ALU result.
- wdata  in  32  store data; byte/half taken from the low bits.
- mem_read  in  1  load request this cycle.
- mem_write  in  1  store request this cycle.
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 is reserved and treated as word.
- ld_unsigned  in  1  1 = zero-extend the load, 0 = sign-extend.
- rdata  out  32  load result, extended to 32 bits.
- misalign  out  1  combinational flag: the current request is misaligned.
- err_valid  out  1  sticky fault flag.
- err_addr  out  32  address of the first unserviced fault.
- err_is_store  out  1  1 = the held fault was a store.
- err_clr  in  1  clears the sticky fault at the next edge.

Behaviour:
- Array indexing:
  - word index = addr[AW+1:2].
  - Upper address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
  - The array is not reset; its contents are undefined after reset.
- Misalignment:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0.
  - misalign = (mem_read|mem_write) & misaligned; 0 when idle.
- Load path (combinational, zero cycles):
  - Select the byte lane addr[1:0] or half lane addr[1], little-endian (byte 0 = bits 7:0).
  - Extend per ld_unsigned.
  - rdata = 0 when mem_read=0, when misalign=1, or while rst_n=0.
- Store path:
  - At the rising edge with mem_write=1 and misalign=0, write only the addressed byte lanes.
  - Unaddressed lanes keep their values.
  - A misaligned store writes nothing.
- Read-during-write, same cycle, same word: rdata shows the pre-store contents; the new data is visible from the next cycle.
- mem_read and mem_write both high:
  - The store is performed.
  - rdata still returns the pre-store contents.
  - Any fault is recorded as a store (err_is_store=1).
- Fault capture at the rising edge, when misalign=1:
  - If err_valid=0: err_valid<=1, err_addr<=addr, err_is_store<=mem_write.
  - If err_valid=1 and err_clr=0: the first fault is held and later faults are dropped.
- err_clr=1 with no new fault: err_valid<=0; err_addr and err_is_store keep their values.
- err_clr=1 with a new fault in the same cycle: the new fault is captured (err_valid stays 1, fields reloaded).
- Reset (asynchronous, any time):
  - err_valid=0, err_addr=0, err_is_store=0, counters=0.
  - A store in flight during reset is not committed.
  - Normal operation resumes at the first edge after rst_n rises.
- Latency: loads 0 cycles (combinational); stores commit at 1 edge; fault capture 1 edge.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs ld_count[31:0] and st_count[31:0].
  - Each counter increments at the edge of every non-faulting load / store respectively.
  - A simultaneous read+write counts as a store only.
  - Counters saturate at 32'hFFFFFFFF.
  - Both reset to 0 and are cleared only by rst_n.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> rdata=0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- After the above, SB addr=0x11 wdata=0x000000AA -> LW 0x10 = 0xDEADAABE? No: must read 0xDEADAAEF. SH 0x12 wdata=0x1234 -> LW 0x10 = 0x1234AAEF.
- LW addr=0x22 -> misalign=1, rdata=0; at the edge err_valid=1, err_addr=0x22, err_is_store=0. Next cycle SH addr=0x31 -> fault dropped, err_addr stays 0x22. Word 0x30 unchanged.
- err_clr=1 alone -> err_valid=0. Then err_clr=1 together with SW addr=0x41 -> err_valid=1, err_addr=0x41, err_is_store=1.
- Same cycle: LW + SW addr=0x50 wdata=0x11111111 over old 0x22222222 -> rdata=0x22222222 that cycle, 0x11111111 the next. Aliasing: with DEPTH_WORDS=256, LW 0x450 -> 0x11111111.
- rst_n pulsed low mid-store (asserted before the edge) -> word not written, err_valid=0. With DMEM_STATS_EN: 3 good loads, 2 good stores, 1 faulting load -> ld_count=3, st_count=2; after reset both 0.
